mips_store_checker: RTL and testbench

Synthesisable, parametrised self-checking harness for the pipelined MIPS core. It sequences the core's `reset` and `hazreset` from one system reset, with `hazreset` released a programmable number of cycles after core reset. It then watches the memory-stage store bus (`memwriteM`, `aluoutM`, `writedataM`) and checks it against a preloaded table of expected stores. It reports PASS, or FAIL with a cause code, on registered status outputs, and replaces the hand-timed reset stimulus in the top-level bench.

---
 rtl/mips_store_checker_if.sv | 38 +++
 rtl/mips_store_checker.sv | 155 +++++++++++++++
 tb/tb_mips_store_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mips_store_checker_if.sv
// Signal bundle between the store checker and its driver: expected-table load port,
// memory-stage store bus from the core, and the checker's registered status/reset outputs.
interface mips_store_checker_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              exp_we;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_data;
   logic              start;
   logic              memwriteM;
   logic [ADDR_W-1:0] aluoutM;
   logic [DATA_W-1:0] writedataM;
   logic              core_reset;
   logic              hazreset;
   logic              done;
   logic              pass;
   logic [1:0]        fail_code;
   logic [CNT_W-1:0]  match_count;
   logic [ADDR_W-1:0] fail_addr;
   logic [DATA_W-1:0] fail_data;
   logic [31:0]       cycle_count;

   modport master (
      output exp_we, exp_addr, exp_data, start, memwriteM, aluoutM, writedataM,
      input  core_reset, hazreset, done, pass, fail_code, match_count,
             fail_addr, fail_data, cycle_count
   );

   modport slave (
      input  exp_we, exp_addr, exp_data, start, memwriteM, aluoutM, writedataM,
      output core_reset, hazreset, done, pass, fail_code, match_count,
             fail_addr, fail_data, cycle_count
   );
endinterface

// File: rtl/mips_store_checker.sv
// Sequences core/hazard reset, then checks the core's M-stage stores against a
// preloaded table of expected (address, data) pairs and reports PASS or FAIL.
module mips_store_checker #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 16,
   parameter int RST_CYCLES = 1,
   parameter int HAZ_EXTRA  = 1,
   parameter int TIMEOUT    = 1024
) (
   input logic                clk,
   input logic                reset,
   mips_store_checker_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [31:0]      RST_C    = 32'(RST_CYCLES);
   localparam logic [31:0]      RST_END  = 32'(RST_CYCLES + HAZ_EXTRA);
   localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT - 1);

   typedef enum logic [2:0] {LOAD, RSTSEQ, RUN, PASS, FAIL} state_t;

   state_t state, state_nxt;
   logic [CNT_W-1:0]  exp_count, exp_count_nxt;
   logic [31:0]       rc, rc_nxt, rc_inc, cnt_inc;
   logic [ADDR_W-1:0] tbl_addr [DEPTH];
   logic [DATA_W-1:0] tbl_data [DEPTH];

   logic              core_reset_nxt, hazreset_nxt, done_nxt, pass_nxt;
   logic [1:0]        fail_code_nxt;
   logic [CNT_W-1:0]  match_count_nxt, match_inc;
   logic [ADDR_W-1:0] fail_addr_nxt;
   logic [DATA_W-1:0] fail_data_nxt;
   logic [31:0]       cycle_count_nxt;

   logic wr_en, store, hit, unexpected, mismatch, matched, complete, timeout;
   logic [IDX_W-1:0] rd_idx, wr_idx;

   assign rd_idx     = bus.match_count[IDX_W-1:0];
   assign wr_idx     = exp_count[IDX_W-1:0];
   assign wr_en      = (state == LOAD) && bus.exp_we && (exp_count < DEPTH_C);
   assign rc_inc     = rc + 32'd1;
   assign cnt_inc    = bus.cycle_count + 32'd1;
   assign match_inc  = bus.match_count + CNT_W'(1);
   assign store      = (state == RUN) && bus.memwriteM;
   assign hit        = (tbl_addr[rd_idx] == bus.aluoutM) && (tbl_data[rd_idx] == bus.writedataM);
   assign unexpected = store && (exp_count == '0);
   assign mismatch   = store && (exp_count != '0) && !hit;
   assign matched    = store && (exp_count != '0) && hit;
   assign complete   = matched && (match_inc == exp_count);
   assign timeout    = (state == RUN) && (cnt_inc == TMO_LAST);

   // Table storage keeps its contents across reset; exp_count alone defines what is live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tbl_addr[wr_idx] <= bus.exp_addr;
         tbl_data[wr_idx] <= bus.exp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= LOAD;
         exp_count       <= '0;
         rc              <= '0;
         bus.core_reset  <= 1'b1;
         bus.hazreset    <= 1'b1;
         bus.done        <= 1'b0;
         bus.pass        <= 1'b0;
         bus.fail_code   <= 2'd0;
         bus.match_count <= '0;
         bus.fail_addr   <= '0;
         bus.fail_data   <= '0;
         bus.cycle_count <= '0;
      end else begin
         state           <= state_nxt;
         exp_count       <= exp_count_nxt;
         rc              <= rc_nxt;
         bus.core_reset  <= core_reset_nxt;
         bus.hazreset    <= hazreset_nxt;
         bus.done        <= done_nxt;
         bus.pass        <= pass_nxt;
         bus.fail_code   <= fail_code_nxt;
         bus.match_count <= match_count_nxt;
         bus.fail_addr   <= fail_addr_nxt;
         bus.fail_data   <= fail_data_nxt;
         bus.cycle_count <= cycle_count_nxt;
      end
   end

   // Store errors and completion take priority over the timeout on the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (bus.start) state_nxt = RSTSEQ;
         RSTSEQ:  if (rc_inc >= RST_END) state_nxt = RUN;
         RUN: begin
            if (unexpected || mismatch)  state_nxt = FAIL;
            else if (complete)           state_nxt = PASS;
            else if (timeout)            state_nxt = (exp_count == '0) ? PASS : FAIL;
         end
         default: state_nxt = state;
      endcase
   end

   always_comb begin
      exp_count_nxt   = exp_count;
      rc_nxt          = rc;
      core_reset_nxt  = bus.core_reset;
      hazreset_nxt    = bus.hazreset;
      done_nxt        = bus.done;
      pass_nxt        = bus.pass;
      fail_code_nxt   = bus.fail_code;
      match_count_nxt = bus.match_count;
      fail_addr_nxt   = bus.fail_addr;
      fail_data_nxt   = bus.fail_data;
      cycle_count_nxt = bus.cycle_count;
      case (state)
         LOAD: begin
            core_reset_nxt = 1'b1;
            hazreset_nxt   = 1'b1;
            rc_nxt         = '0;
            if (wr_en) exp_count_nxt = exp_count + CNT_W'(1);
         end
         RSTSEQ: begin
            rc_nxt         = rc_inc;
            core_reset_nxt = (rc_inc < RST_C);
            hazreset_nxt   = (rc_inc < RST_END);
         end
         RUN: begin
            cycle_count_nxt = cnt_inc;
            if (matched) match_count_nxt = match_inc;
            if (unexpected || mismatch) begin
               fail_addr_nxt = bus.aluoutM;
               fail_data_nxt = bus.writedataM;
            end
         end
         default: ;
      endcase
      // Terminal entry freezes the core under reset.
      if (state == RUN && state_nxt == PASS) begin
         done_nxt       = 1'b1;
         pass_nxt       = 1'b1;
         core_reset_nxt = 1'b1;
         hazreset_nxt   = 1'b1;
      end else if (state == RUN && state_nxt == FAIL) begin
         done_nxt       = 1'b1;
         pass_nxt       = 1'b0;
         core_reset_nxt = 1'b1;
         hazreset_nxt   = 1'b1;
         fail_code_nxt  = unexpected ? 2'd3 : (mismatch ? 2'd1 : 2'd2);
      end
   end
endmodule

// File: tb/tb_mips_store_checker.sv
// Directed bench for mips_store_checker: reset sequencing, pass/mismatch/timeout/
// unexpected-store outcomes, table capacity, concurrent load+start and mid-run reset.
module tb_mips_store_checker;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fails  = 0;

   mips_store_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   mips_store_checker #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
      .RST_CYCLES(2), .HAZ_EXTRA(1), .TIMEOUT(8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      bus.exp_we = 1'b1; bus.exp_addr = a; bus.exp_data = d;
      tick();
      bus.exp_we = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.memwriteM = 1'b1; bus.aluoutM = a; bus.writedataM = d;
      tick();
      bus.memwriteM = 1'b0;
   endtask

   task automatic start_seq();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      bus.exp_we = 1'b0; bus.exp_addr = '0; bus.exp_data = '0; bus.start = 1'b0;
      bus.memwriteM = 1'b0; bus.aluoutM = '0; bus.writedataM = '0;

      // Reset values
      do_reset();
      chk("rst_core_reset", 64'(bus.core_reset), 64'd1);
      chk("rst_hazreset", 64'(bus.hazreset), 64'd1);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_pass", 64'(bus.pass), 64'd0);
      chk("rst_fail_code", 64'(bus.fail_code), 64'd0);
      chk("rst_match_count", 64'(bus.match_count), 64'd0);
      chk("rst_fail_addr", 64'(bus.fail_addr), 64'd0);
      chk("rst_fail_data", 64'(bus.fail_data), 64'd0);
      chk("rst_cycle_count", 64'(bus.cycle_count), 64'd0);

      // Three matching stores, with reset-sequence timing checked edge by edge
      load(32'h54, 32'h7); load(32'h50, 32'h7); load(32'h58, 32'h5);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("seq0_core_reset", 64'(bus.core_reset), 64'd1);
      tick();
      chk("seq1_core_reset", 64'(bus.core_reset), 64'd1);
      chk("seq1_hazreset", 64'(bus.hazreset), 64'd1);
      tick();
      chk("seq2_core_reset", 64'(bus.core_reset), 64'd0);
      chk("seq2_hazreset", 64'(bus.hazreset), 64'd1);
      tick();
      chk("seq3_hazreset", 64'(bus.hazreset), 64'd0);
      chk("seq3_core_reset", 64'(bus.core_reset), 64'd0);
      store(32'h54, 32'h7);
      chk("p1_match_count", 64'(bus.match_count), 64'd1);
      chk("p1_done", 64'(bus.done), 64'd0);
      store(32'h50, 32'h7);
      store(32'h58, 32'h5);
      chk("p_match_count", 64'(bus.match_count), 64'd3);
      chk("p_done", 64'(bus.done), 64'd1);
      chk("p_pass", 64'(bus.pass), 64'd1);
      chk("p_fail_code", 64'(bus.fail_code), 64'd0);
      chk("p_core_reset", 64'(bus.core_reset), 64'd1);
      chk("p_hazreset", 64'(bus.hazreset), 64'd1);
      chk("p_cycle_count", 64'(bus.cycle_count), 64'd3);
      tick();
      chk("p_cycle_frozen", 64'(bus.cycle_count), 64'd3);

      // Data mismatch on the second store
      do_reset();
      load(32'h54, 32'h7); load(32'h50, 32'h7); load(32'h58, 32'h5);
      start_seq();
      store(32'h54, 32'h7);
      store(32'h50, 32'h8);
      chk("mm_done", 64'(bus.done), 64'd1);
      chk("mm_pass", 64'(bus.pass), 64'd0);
      chk("mm_fail_code", 64'(bus.fail_code), 64'd1);
      chk("mm_fail_addr", 64'(bus.fail_addr), 64'h50);
      chk("mm_fail_data", 64'(bus.fail_data), 64'h8);
      chk("mm_match_count", 64'(bus.match_count), 64'd1);
      store(32'h58, 32'h9);
      chk("mm_frozen_data", 64'(bus.fail_data), 64'h8);

      // Timeout with one pending entry
      do_reset();
      load(32'h40, 32'h1);
      start_seq();
      repeat (6) tick();
      chk("to_not_yet", 64'(bus.done), 64'd0);
      tick();
      chk("to_done", 64'(bus.done), 64'd1);
      chk("to_fail_code", 64'(bus.fail_code), 64'd2);
      chk("to_cycle_count", 64'(bus.cycle_count), 64'd7);
      chk("to_pass", 64'(bus.pass), 64'd0);

      // Empty table, no stores: passes at the timeout
      do_reset();
      start_seq();
      repeat (7) tick();
      chk("empty_done", 64'(bus.done), 64'd1);
      chk("empty_pass", 64'(bus.pass), 64'd1);
      chk("empty_fail_code", 64'(bus.fail_code), 64'd0);

      // Empty table, unexpected store
      do_reset();
      start_seq();
      store(32'h10, 32'h3);
      chk("unx_fail_code", 64'(bus.fail_code), 64'd3);
      chk("unx_fail_addr", 64'(bus.fail_addr), 64'h10);
      chk("unx_fail_data", 64'(bus.fail_data), 64'h3);
      chk("unx_done", 64'(bus.done), 64'd1);

      // Six writes into a four-entry table: only the first four are live
      do_reset();
      for (int i = 0; i < 6; i++) load(32'h100 + 32'(4 * i), 32'(i + 1));
      start_seq();
      for (int i = 0; i < 3; i++) store(32'h100 + 32'(4 * i), 32'(i + 1));
      chk("cap_done_after3", 64'(bus.done), 64'd0);
      store(32'h10c, 32'h4);
      chk("cap_pass", 64'(bus.pass), 64'd1);
      chk("cap_match_count", 64'(bus.match_count), 64'd4);

      // Write in the same cycle as start is counted
      do_reset();
      load(32'h20, 32'h1);
      bus.exp_we = 1'b1; bus.exp_addr = 32'h24; bus.exp_data = 32'h2; bus.start = 1'b1;
      tick();
      bus.exp_we = 1'b0; bus.start = 1'b0;
      repeat (3) tick();
      store(32'h20, 32'h1);
      chk("cc_done_after1", 64'(bus.done), 64'd0);
      store(32'h24, 32'h2);
      chk("cc_pass", 64'(bus.pass), 64'd1);
      chk("cc_match_count", 64'(bus.match_count), 64'd2);

      // Reset during RUN returns to LOAD with an empty table
      do_reset();
      load(32'h30, 32'h5); load(32'h34, 32'h6);
      start_seq();
      store(32'h30, 32'h5);
      chk("mr_match_before", 64'(bus.match_count), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_core_reset", 64'(bus.core_reset), 64'd1);
      chk("mr_hazreset", 64'(bus.hazreset), 64'd1);
      chk("mr_match_count", 64'(bus.match_count), 64'd0);
      chk("mr_cycle_count", 64'(bus.cycle_count), 64'd0);
      start_seq();
      store(32'h34, 32'h6);
      chk("mr_table_unreachable", 64'(bus.fail_code), 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
